// File: rtl/autotune_pkg.sv
// Shared types for the audio front end: I2S sample width, framer state encoding
// and the offset-binary to two's-complement conversion.
package autotune_pkg;

    localparam int unsigned I2S_SAMPLE_WIDTH   = 24;
    localparam int unsigned FRAME_SAMPLE_WIDTH = 16;

    typedef logic signed [FRAME_SAMPLE_WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STREAM
    } framer_state_t;

    function automatic logic signed [I2S_SAMPLE_WIDTH-1:0] to_signed(
        input logic [I2S_SAMPLE_WIDTH-1:0] ob
    );
        return {~ob[I2S_SAMPLE_WIDTH-1], ob[I2S_SAMPLE_WIDTH-2:0]};
    endfunction

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample store: one write port, one registered read port with
// read enable so the output holds while the consumer stalls.
module sample_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read-first: a read colliding with a write returns the previous contents.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)  rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sample_framer.sv
// Circular-buffer framer: stores converted samples and streams the latest
// WINDOW_SIZE of them every HOP_SIZE writes. Optional DC blocker: SAMPLE_FRAMER_DC_BLOCK_EN.
module sample_framer
    import autotune_pkg::*;
#(
    parameter int unsigned WINDOW_SIZE  = 1024,
    parameter int unsigned HOP_SIZE     = 512,
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned DC_SHIFT     = 10
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [23:0]             sample_in,
    input  logic                    sample_valid_in,
    output logic [SAMPLE_WIDTH-1:0] frame_data_out,
    output logic                    frame_valid_out,
    input  logic                    frame_ready_in,
    output logic                    frame_last_out,
    output logic                    overrun_out
);

    localparam int unsigned AW = $clog2(WINDOW_SIZE);
    localparam int unsigned CW = $clog2(WINDOW_SIZE + 1);
    localparam int unsigned HW = (HOP_SIZE > 1) ? $clog2(HOP_SIZE) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(WINDOW_SIZE - 1);

    framer_state_t            state;
    logic [AW-1:0]            wr_ptr, base, idx, wr_off, rd_addr;
    logic [CW-1:0]            prime_cnt;
    logic [HW-1:0]            hop_cnt;
    logic                     primed, trig, rd_en;
    logic signed [23:0]       conv, filt;
    logic [SAMPLE_WIDTH-1:0]  wr_data;

    assign conv = to_signed(sample_in);

`ifdef SAMPLE_FRAMER_DC_BLOCK_EN
    logic signed [23:0] x_prev, y_prev, y_sat;
    logic signed [25:0] y_full;

    // Two guard bits absorb the worst-case sum before saturating back to 24 bits.
    always_comb begin
        y_full = 26'(conv) - 26'(x_prev) + 26'(y_prev) - 26'(y_prev >>> DC_SHIFT);
        if (y_full[25:23] == 3'b000 || y_full[25:23] == 3'b111)
            y_sat = y_full[23:0];
        else
            y_sat = y_full[25] ? 24'sh800000 : 24'sh7FFFFF;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            x_prev <= '0;
            y_prev <= '0;
        end else if (sample_valid_in) begin
            x_prev <= conv;
            y_prev <= y_sat;
        end
    end

    assign filt = y_sat;
`else
    logic unused_dc_shift;
    assign unused_dc_shift = (DC_SHIFT != 0);
    assign filt = conv;
`endif

    assign wr_data = SAMPLE_WIDTH'(filt >>> (24 - SAMPLE_WIDTH));
    assign primed  = (prime_cnt == CW'(WINDOW_SIZE));
    assign trig    = sample_valid_in &&
                     ((!primed && prime_cnt == CW'(WINDOW_SIZE - 1)) ||
                      (primed && hop_cnt == HW'(HOP_SIZE - 1)));
    assign wr_off  = wr_ptr - base;

    // The RAM output register is the data register; reading the next slot on each
    // handshake gives one beat per cycle without a separate skid buffer.
    assign rd_addr = (state == FETCH) ? base : base + idx + 1'b1;
    assign rd_en   = (state == FETCH) ||
                     (state == STREAM && frame_ready_in && idx != LAST_IDX);

    sample_ram #(
        .DEPTH (WINDOW_SIZE),
        .WIDTH (SAMPLE_WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .wr_en    (sample_valid_in),
        .wr_addr  (wr_ptr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (frame_data_out)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            base            <= '0;
            idx             <= '0;
            prime_cnt       <= '0;
            hop_cnt         <= '0;
            frame_valid_out <= 1'b0;
            frame_last_out  <= 1'b0;
            overrun_out     <= 1'b0;
        end else begin
            if (sample_valid_in) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (!primed)
                    prime_cnt <= prime_cnt + 1'b1;
                else if (hop_cnt == HW'(HOP_SIZE - 1))
                    hop_cnt <= '0;
                else
                    hop_cnt <= hop_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (trig) begin
                        base        <= wr_ptr + 1'b1;
                        idx         <= '0;
                        overrun_out <= 1'b0;
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    frame_valid_out <= 1'b1;
                    frame_last_out  <= 1'b0;
                    state           <= STREAM;
                end
                STREAM: begin
                    if (frame_ready_in) begin
                        if (idx == LAST_IDX) begin
                            frame_valid_out <= 1'b0;
                            frame_last_out  <= 1'b0;
                            state           <= IDLE;
                        end else begin
                            idx            <= idx + 1'b1;
                            frame_last_out <= (idx == LAST_IDX - 1'b1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (state != IDLE && (trig || (sample_valid_in && wr_off >= idx)))
                overrun_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sample_framer.sv
// Directed bench for sample_framer with WINDOW_SIZE=8, HOP_SIZE=4, SAMPLE_WIDTH=16.
module tb_sample_framer;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int SW = 16;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic [23:0]   sample_in;
    logic          sample_valid_in;
    logic [SW-1:0] frame_data_out;
    logic          frame_valid_out;
    logic          frame_ready_in;
    logic          frame_last_out;
    logic          overrun_out;

    always #5 clk_in = ~clk_in;

    sample_framer #(
        .WINDOW_SIZE  (W),
        .HOP_SIZE     (H),
        .SAMPLE_WIDTH (SW),
        .DC_SHIFT     (10)
    ) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid_in),
        .frame_data_out  (frame_data_out),
        .frame_valid_out (frame_valid_out),
        .frame_ready_in  (frame_ready_in),
        .frame_last_out  (frame_last_out),
        .overrun_out     (overrun_out)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rlo_s  = -1;
    int rlo_e  = -1;
    int c0;

    logic [15:0] bd[$];
    logic        bl[$];
    int          rises[$];
    int          strobe_cyc[$];
    logic [23:0] svals[$];
    logic        pv = 1'b0;
    logic        pr = 1'b1;
    logic [15:0] pd = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1: drive this cycle's inputs, observe outputs, advance one clock.
    task automatic tick(input logic sv, input logic [23:0] s);
        sample_valid_in = sv;
        sample_in       = s;
        frame_ready_in  = !(cyc >= rlo_s && cyc < rlo_e);
        if (sv) strobe_cyc.push_back(cyc);
        if (pv && !pr) begin
            chk("stall_valid", 32'(frame_valid_out), 32'd1);
            chk("stall_data", 32'(frame_data_out), 32'(pd));
        end
        if (frame_valid_out && !pv) rises.push_back(cyc);
        if (frame_valid_out && frame_ready_in) begin
            bd.push_back(frame_data_out);
            bl.push_back(frame_last_out);
        end
        pv = frame_valid_out;
        pr = frame_ready_in;
        pd = frame_data_out;
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic push_k(input int k0, input int n);
        for (int i = 0; i < n; i++)
            svals.push_back(24'h800000 + 24'((k0 + i) << 8));
    endtask

    task automatic feed();
        while (svals.size() > 0) begin
            tick(1'b1, svals.pop_front());
            repeat (39) tick(1'b0, '0);
        end
    endtask

    task automatic clear();
        bd.delete();
        bl.delete();
        rises.delete();
        strobe_cyc.delete();
    endtask

    task automatic check_frame(input string tag, input logic [15:0] exp [8], input int trig_idx);
        chk({tag, "_beats"}, 32'(bd.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_data"}, (i < bd.size()) ? 32'(bd[i]) : 'x, 32'(exp[i]));
            chk({tag, "_last"}, (i < bl.size()) ? 32'(bl[i]) : 'x, (i == 7) ? 32'd1 : 32'd0);
        end
        chk({tag, "_frames"}, 32'(rises.size()), 32'd1);
        chk({tag, "_latency"},
            (rises.size() > 0 && strobe_cyc.size() > trig_idx) ? 32'(rises[0] - strobe_cyc[trig_idx]) : 32'hFFFF_FFFF,
            32'd2);
    endtask

    initial begin
        rst_n_in        = 1'b0;
        sample_valid_in = 1'b0;
        sample_in       = '0;
        frame_ready_in  = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_valid", 32'(frame_valid_out), 32'd0);
        chk("rst_last", 32'(frame_last_out), 32'd0);
        chk("rst_overrun", 32'(overrun_out), 32'd0);
        chk("rst_data", 32'(frame_data_out), 32'd0);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;

        // Prime: exactly one frame 0..7 after the 8th strobe.
        clear();
        push_k(0, 8);
        feed();
        check_frame("prime", '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7}, 7);
        chk("prime_overrun", 32'(overrun_out), 32'd0);

        // Hop: next frame at the 12th strobe holds 4..11.
        clear();
        push_k(8, 4);
        feed();
        check_frame("hop", '{16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11}, 3);

        // Backpressure: ready 1-0-0-1 across beats 1..3.
        clear();
        c0    = cyc;
        rlo_s = c0 + 124;
        rlo_e = rlo_s + 2;
        push_k(12, 4);
        feed();
        check_frame("bp", '{16'd8, 16'd9, 16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15}, 3);

        // Overrun: ready low 200 cycles after frame start; writes 20..24 overwrite
        // slots behind beat 0, the hop at 23 is dropped.
        clear();
        c0    = cyc;
        rlo_s = c0 + 122;
        rlo_e = c0 + 322;
        push_k(16, 9);
        feed();
        check_frame("ovr", '{16'd12, 16'd21, 16'd22, 16'd23, 16'd24, 16'd17, 16'd18, 16'd19}, 3);
        chk("ovr_flag", 32'(overrun_out), 32'd1);

        clear();
        push_k(25, 3);
        feed();
        check_frame("post", '{16'd20, 16'd21, 16'd22, 16'd23, 16'd24, 16'd25, 16'd26, 16'd27}, 2);
        chk("post_overrun", 32'(overrun_out), 32'd0);

        // Sign conversion extremes.
        clear();
        svals.push_back(24'h000000);
        svals.push_back(24'hFFFFFF);
        push_k(30, 2);
        feed();
        check_frame("sign", '{16'd24, 16'd25, 16'd26, 16'd27, 16'h8000, 16'h7FFF, 16'd30, 16'd31}, 3);

        // Reset at beat 3 of the frame triggered by strobe 35.
        clear();
        push_k(32, 3);
        feed();
        tick(1'b1, 24'h800000 + 24'(35 << 8));
        repeat (4) tick(1'b0, '0);
        chk("mid_valid", 32'(frame_valid_out), 32'd1);
        chk("mid_data", 32'(frame_data_out), 32'd31);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("async_valid", 32'(frame_valid_out), 32'd0);
        chk("async_last", 32'(frame_last_out), 32'd0);
        chk("async_data", 32'(frame_data_out), 32'd0);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        pv       = 1'b0;
        pr       = 1'b1;
        cyc++;

        clear();
        push_k(40, 7);
        feed();
        chk("rst_reprime", 32'(rises.size()), 32'd0);
        clear();
        push_k(47, 1);
        feed();
        check_frame("rst_frame", '{16'd40, 16'd41, 16'd42, 16'd43, 16'd44, 16'd45, 16'd46, 16'd47}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_framer.md
Name: sample_framer

Overview:
Downstream of the I2S receiver. Consumes one 24-bit offset-binary sample per valid pulse, converts each to signed and truncates it to SAMPLE_WIDTH, and stores it in a circular buffer. Every HOP_SIZE samples it streams the most recent WINDOW_SIZE samples, oldest first, over a valid/ready interface with a last flag. Feeds the pitch-analysis/FFT stage.

Parameters:
WINDOW_SIZE, 1024, samples per frame; power of two, at least 4.
HOP_SIZE, 512, new samples between frame starts; 1 to WINDOW_SIZE.
SAMPLE_WIDTH, 16, output sample width; at most 24.
DC_SHIFT, 10, DC-blocker pole shift; used only with the optional feature.

Ports:
clk_in  input  1  system clock, 100 MHz
rst_n_in  input  1  asynchronous active-low reset
sample_in  input  24  offset-binary sample (MSB inverted)
sample_valid_in  input  1  single-cycle strobe; sample_in is valid this cycle
frame_data_out  output  SAMPLE_WIDTH  signed sample
frame_valid_out  output  1  frame_data_out is valid
frame_ready_in  input  1  downstream accepts the beat
frame_last_out  output  1  marks the final (WINDOW_SIZE-th) beat of a frame
overrun_out  output  1  sticky per frame: an unread slot was overwritten or a hop was dropped

Behaviour:
- Reset is asynchronous on rst_n_in low. All outputs go to 0. Write pointer, prime counter, hop counter and FSM clear.
- Conversion: signed sample is {~sample_in[23], sample_in[22:0]}. Keep bits [23:24-SAMPLE_WIDTH] (truncate, no rounding).
- Write: on sample_valid_in the sample is written at wr_ptr, then wr_ptr increments modulo WINDOW_SIZE. Writes are never blocked.
- Prime: no frame is emitted until WINDOW_SIZE samples have been written since reset. The prime counter saturates.
- Hop counter counts writes after priming. A trigger fires on the write that completes priming, then on every HOP_SIZE-th write after it.
- FSM states:
  - IDLE: a trigger latches base = post-increment wr_ptr (the oldest sample), clears the read index and overrun_out, and goes to FETCH.
  - FETCH: issues the RAM read at base+idx. RAM read latency is 1 cycle. Goes to STREAM.
  - STREAM: holds frame_valid_out and data until frame_ready_in.
    - On a handshake with idx < WINDOW_SIZE-1: idx++ and the next read is prefetched. Back-to-back beats at full throughput are required (one-entry prefetch/skid).
    - On a handshake with idx == WINDOW_SIZE-1: frame_last_out is high for that beat, then go to IDLE.
- Latency: frame_valid_out is asserted exactly 2 cycles after the triggering sample_valid_in.
- Trigger while not in IDLE: the hop is dropped and overrun_out is set. The hop counter still restarts, so cadence is preserved.
- Overwrite check: a write during streaming whose slot offset from base is at least idx (not yet read) sets overrun_out. Streaming continues, and the stale/new data is delivered as-is.
- frame_valid_out never drops without a handshake. Data is stable while valid && !ready.
- sample_valid_in, a handshake and a trigger may all occur in the same cycle. The write happens first, and the read address logic must not use the just-written slot unless offset ≥ idx.
- Reset mid-frame: the frame is abandoned, valid drops immediately, and priming restarts.

Optional Feature:
SAMPLE_FRAMER_DC_BLOCK_EN.
- Defined: a first-order DC blocker sits between conversion and truncation, y = x - x_prev + y_prev - (y_prev >>> DC_SHIFT).
  - State is 24 bits plus 2 guard bits, saturating to 24 bits. It updates only on sample_valid_in and resets to 0.
  - Latency to the RAM is unchanged: combinational into the write.
- Undefined: samples are stored as converted/truncated, and DC_SHIFT is ignored.

Decomposition:
- Package autotune_pkg:
  - I2S_SAMPLE_WIDTH=24
  - typedef sample_t (signed SAMPLE_WIDTH)
  - typedef framer_state_t enum {IDLE, FETCH, STREAM}
- Sub-module sample_ram: simple dual-port, one write port and one registered-read port, WINDOW_SIZE × SAMPLE_WIDTH, inferable as BRAM.

Test Plan:
All scenarios use bench parameters WINDOW_SIZE=8, HOP_SIZE=4, SAMPLE_WIDTH=16, ready held high unless stated.
- Prime: feed sample_in=0x800000+(k<<8) for k=0..7, one strobe per 40 cycles -> exactly one frame 0..7. frame_last_out only on value 7. First valid 2 cycles after the 8th strobe. overrun_out=0.
- Hop: continue with k=8..11 -> second frame 4..11, with no frame before the 12th strobe.
- Backpressure: toggle frame_ready_in 1-0-0-1 during a frame -> all 8 beats in order, data stable during stalls, no duplicates or skips.
- Overrun: hold ready low for 5 strobe periods after a frame starts -> overrun_out=1. The dropped hop produces no extra frame. The next frame after release starts on the following hop boundary.
- Sign conversion: sample_in=0x000000 -> 0x8000; sample_in=0xFFFFFF -> 0x7FFF.
- Reset mid-frame: assert rst_n_in low at beat 3 -> valid low asynchronously. After release, no frame until 8 new strobes.
